// File: rtl/usb_ebi_master_pkg.sv
// Shared definitions for the USB external-bus initiator: FSM state encoding,
// default bus timing and the phase-counter width helper.
package usb_ebi_master_pkg;

  // Bus widths of the multiplexed external bus
  localparam int unsigned EBI_AW = 8;
  localparam int unsigned EBI_DW = 8;

  // Default timing in clk cycles; the responder's bench model uses the same values
  localparam int unsigned DEF_T_ALE = 2;
  localparam int unsigned DEF_T_AH  = 1;
  localparam int unsigned DEF_T_STB = 3;
  localparam int unsigned DEF_T_REC = 2;
  localparam int unsigned DEF_LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_AHOLD  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STROBE = 3'd4,
    ST_REC    = 3'd5
  } ebi_state_e;

  // Phase counter width: enough bits for the longest phase, plus one
  function automatic int unsigned phase_width(input int unsigned t_ale,
                                              input int unsigned t_ah,
                                              input int unsigned t_stb,
                                              input int unsigned t_rec);
    int unsigned m;
    m = t_ale;
    if (t_ah  > m) m = t_ah;
    if (t_stb > m) m = t_stb;
    if (t_rec > m) m = t_rec;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/usb_ebi_phase_timer.sv
// Loadable down-counter used to time each bus phase.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   load          load load_val this cycle (wins over counting)
//   load_val      phase length minus one
//   zero_c        combinational flag: counter has reached zero
module usb_ebi_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // Count down and park at zero until the next load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/usb_ebi_master.sv
// Initiator for the 8-bit multiplexed USB external bus. Converts a command
// handshake plus write/read byte streams into timed ALE/CE/RD/WR cycles; a
// burst of cmd_len bytes shares a single address phase.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   cmd_valid/ready/write/addr/len command handshake (ready only in IDLE)
//   wr_data/wr_valid/wr_ready     write byte stream (wr_ready pulses on consume)
//   rd_data/rd_valid/rd_ready     read byte stream (byte held until accepted)
//   done, busy                    burst-complete pulse, not-idle flag
//   usb_addr, usb_d_o, usb_d_oe   address bus, data out and its drive enable
//   usb_d_i                       data in (tristate handled at top level)
//   usb_alen/cen/rdn/wrn          active-low bus strobes
// All outputs are registered so the pins never glitch.
module usb_ebi_master
  import usb_ebi_master_pkg::*;
#(
  parameter int unsigned T_ALE = DEF_T_ALE,
  parameter int unsigned T_AH  = DEF_T_AH,
  parameter int unsigned T_STB = DEF_T_STB,
  parameter int unsigned T_REC = DEF_T_REC,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [EBI_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [EBI_DW-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [EBI_DW-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              busy,
  output logic [EBI_AW-1:0] usb_addr,
  output logic [EBI_DW-1:0] usb_d_o,
  input  logic [EBI_DW-1:0] usb_d_i,
  output logic              usb_d_oe,
  output logic              usb_alen,
  output logic              usb_cen,
  output logic              usb_rdn,
  output logic              usb_wrn
);

  localparam int unsigned PH_W = phase_width(T_ALE, T_AH, T_STB, T_REC);
  localparam logic [PH_W-1:0] LD_ALE = PH_W'(T_ALE - 1);
  localparam logic [PH_W-1:0] LD_AH  = PH_W'(T_AH - 1);
  localparam logic [PH_W-1:0] LD_STB = PH_W'(T_STB - 1);
  localparam logic [PH_W-1:0] LD_REC = PH_W'(T_REC - 1);

  ebi_state_e        state, state_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;
  logic              dir_wr, dir_wr_nxt;

  logic              tmr_load;
  logic [PH_W-1:0]   tmr_val;
  logic              tmr_zero_c;

  logic [EBI_AW-1:0] addr_nxt;
  logic [EBI_DW-1:0] d_o_nxt;
  logic [EBI_DW-1:0] rd_data_nxt;
  logic              oe_nxt, alen_nxt, cen_nxt, rdn_nxt, wrn_nxt;
  logic              wr_ready_nxt, rd_valid_nxt, done_nxt;
  logic              cmd_ready_nxt, busy_nxt;

  usb_ebi_phase_timer #(.W(PH_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    dir_wr_nxt    = dir_wr;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    addr_nxt      = usb_addr;
    d_o_nxt       = usb_d_o;
    oe_nxt        = usb_d_oe;
    alen_nxt      = usb_alen;
    cen_nxt       = usb_cen;
    rdn_nxt       = usb_rdn;
    wrn_nxt       = usb_wrn;
    wr_ready_nxt  = 1'b0;
    done_nxt      = 1'b0;
    rd_data_nxt   = rd_data;
    // A pending read byte clears when accepted unless a new capture replaces it
    rd_valid_nxt  = rd_valid & ~rd_ready;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = ST_ADDR;
            rem_nxt    = cmd_len;
            dir_wr_nxt = cmd_write;
            addr_nxt   = cmd_addr;
            cen_nxt    = 1'b0;
            alen_nxt   = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = LD_ALE;
          end
        end
      end
      ST_ADDR: begin
        if (tmr_zero_c) begin
          state_nxt = ST_AHOLD;
          alen_nxt  = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LD_AH;
        end
      end
      ST_AHOLD: begin
        if (tmr_zero_c) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Reads only start once the previous byte is gone, so data is never lost
        if (dir_wr && wr_valid) begin
          state_nxt    = ST_STROBE;
          wrn_nxt      = 1'b0;
          d_o_nxt      = wr_data;
          oe_nxt       = 1'b1;
          wr_ready_nxt = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = LD_STB;
        end else if (!dir_wr && (!rd_valid || rd_ready)) begin
          state_nxt = ST_STROBE;
          rdn_nxt   = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = LD_STB;
        end
      end
      ST_STROBE: begin
        if (tmr_zero_c) begin
          state_nxt = ST_REC;
          rdn_nxt   = 1'b1;
          wrn_nxt   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LD_REC;
          if (!dir_wr) begin
            rd_data_nxt  = usb_d_i;
            rd_valid_nxt = 1'b1;
          end
        end
      end
      ST_REC: begin
        if (tmr_zero_c) begin
          oe_nxt  = 1'b0;
          rem_nxt = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_nxt = ST_IDLE;
            cen_nxt   = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cen_nxt   = 1'b1;
        alen_nxt  = 1'b1;
        rdn_nxt   = 1'b1;
        wrn_nxt   = 1'b1;
        oe_nxt    = 1'b0;
      end
    endcase

    cmd_ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt      = (state_nxt != ST_IDLE);
  end

  // State and registered outputs; reset drives strobes inactive immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rem       <= '0;
      dir_wr    <= 1'b0;
      usb_addr  <= '0;
      usb_d_o   <= '0;
      usb_d_oe  <= 1'b0;
      usb_alen  <= 1'b1;
      usb_cen   <= 1'b1;
      usb_rdn   <= 1'b1;
      usb_wrn   <= 1'b1;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      dir_wr    <= dir_wr_nxt;
      usb_addr  <= addr_nxt;
      usb_d_o   <= d_o_nxt;
      usb_d_oe  <= oe_nxt;
      usb_alen  <= alen_nxt;
      usb_cen   <= cen_nxt;
      usb_rdn   <= rdn_nxt;
      usb_wrn   <= wrn_nxt;
      wr_ready  <= wr_ready_nxt;
      rd_data   <= rd_data_nxt;
      rd_valid  <= rd_valid_nxt;
      done      <= done_nxt;
      cmd_ready <= cmd_ready_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_usb_ebi_master.sv
// Self-checking bench for usb_ebi_master: a procedural timeline model predicts
// every output each cycle; a negedge process compares; directed scenarios add
// literal checks on pulse counts and data order.
module tb_usb_ebi_master;

  localparam int unsigned T_ALE = 2;
  localparam int unsigned T_AH  = 1;
  localparam int unsigned T_STB = 3;
  localparam int unsigned T_REC = 2;
  localparam int unsigned LEN_W = 16;

  logic clk, reset_n;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0] wr_data, rd_data, usb_addr, usb_d_o, usb_d_i;
  logic wr_valid, wr_ready, rd_valid, rd_ready, done, busy;
  logic usb_d_oe, usb_alen, usb_cen, usb_rdn, usb_wrn;

  usb_ebi_master #(.T_ALE(T_ALE), .T_AH(T_AH), .T_STB(T_STB), .T_REC(T_REC), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .busy(busy),
    .usb_addr(usb_addr), .usb_d_o(usb_d_o), .usb_d_i(usb_d_i), .usb_d_oe(usb_d_oe),
    .usb_alen(usb_alen), .usb_cen(usb_cen), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model expectations for the current cycle
  logic       exp_alen, exp_cen, exp_rdn, exp_wrn, exp_oe;
  logic       exp_cmd_ready, exp_busy, exp_done, exp_wr_ready, exp_rd_valid;
  logic [7:0] exp_addr, exp_d_o, exp_rd_data;

  int unsigned rdy_mode;   // 0 random consumer, 1 always ready
  int unsigned rd_hold;    // cycles to force rd_ready low
  logic [7:0]  rd_seed;
  logic [7:0]  wq[$];        // write bytes to send (random if empty)
  logic [7:0]  consumed[$];  // read bytes handed to the consumer (model view)
  logic [7:0]  wr_seen[$];   // usb_d_o at each WRn falling edge

  // Bus monitor counters
  int mon_alen_low, mon_ale_pulses, mon_wrn_low, mon_wrn_pulses, mon_rdn_pulses;
  int mon_oe_cycles, mon_strobe_low, mon_done, mon_cmd_ready_low;
  logic prev_alen = 1'b1, prev_wrn = 1'b1, prev_rdn = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Per-cycle compare against the model plus bus monitoring
  always @(negedge clk) begin
    chk("usb_alen", 32'(usb_alen), 32'(exp_alen));
    chk("usb_cen", 32'(usb_cen), 32'(exp_cen));
    chk("usb_rdn", 32'(usb_rdn), 32'(exp_rdn));
    chk("usb_wrn", 32'(usb_wrn), 32'(exp_wrn));
    chk("usb_d_oe", 32'(usb_d_oe), 32'(exp_oe));
    chk("usb_addr", 32'(usb_addr), 32'(exp_addr));
    chk("usb_d_o", 32'(usb_d_o), 32'(exp_d_o));
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("wr_ready", 32'(wr_ready), 32'(exp_wr_ready));
    chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
    chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
    if (!usb_alen) mon_alen_low++;
    if (prev_alen && !usb_alen) mon_ale_pulses++;
    if (!usb_wrn) mon_wrn_low++;
    if (prev_wrn && !usb_wrn) begin mon_wrn_pulses++; wr_seen.push_back(usb_d_o); end
    if (prev_rdn && !usb_rdn) mon_rdn_pulses++;
    if (usb_d_oe) mon_oe_cycles++;
    if (!usb_alen || !usb_cen || !usb_rdn || !usb_wrn) mon_strobe_low++;
    if (done) mon_done++;
    if (!cmd_ready) mon_cmd_ready_low++;
    prev_alen = usb_alen;
    prev_wrn  = usb_wrn;
    prev_rdn  = usb_rdn;
  end

  task automatic clr_mon();
    mon_alen_low = 0; mon_ale_pulses = 0; mon_wrn_low = 0; mon_wrn_pulses = 0;
    mon_rdn_pulses = 0; mon_oe_cycles = 0; mon_strobe_low = 0; mon_done = 0;
    mon_cmd_ready_low = 0;
    consumed.delete();
    wr_seen.delete();
  endtask

  task automatic set_reset_exp();
    exp_alen = 1; exp_cen = 1; exp_rdn = 1; exp_wrn = 1; exp_oe = 0;
    exp_cmd_ready = 1; exp_busy = 0; exp_done = 0; exp_wr_ready = 0;
    exp_rd_valid = 0; exp_addr = 0; exp_d_o = 0; exp_rd_data = 0;
  endtask

  // Advance one cycle; cap means the DUT must capture capv on this edge
  task automatic tick(input bit cap, input logic [7:0] capv);
    logic       nv;
    logic [7:0] nd;
    nv = exp_rd_valid;
    nd = exp_rd_data;
    if (rd_ready && exp_rd_valid) consumed.push_back(exp_rd_data);
    if (cap) begin nv = 1'b1; nd = capv; end
    else if (rd_ready) nv = 1'b0;
    @(posedge clk);
    #1;
    exp_rd_valid = nv;
    exp_rd_data  = nd;
    exp_done     = 1'b0;
    exp_wr_ready = 1'b0;
    if (rd_hold > 0) begin rd_ready = 1'b0; rd_hold--; end
    else if (rdy_mode == 1) rd_ready = 1'b1;
    else rd_ready = 1'($urandom % 2);
  endtask

  // Asynchronous reset in the middle of a cycle
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_alen", 32'(usb_alen), 32'd1);
    chk("t6_async_cen", 32'(usb_cen), 32'd1);
    chk("t6_async_wrn", 32'(usb_wrn), 32'd1);
    chk("t6_async_rdn", 32'(usb_rdn), 32'd1);
    chk("t6_async_oe", 32'(usb_d_oe), 32'd0);
    set_reset_exp();
    wr_valid = 1'b0;
    rd_hold  = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Issue one command and walk the model through the whole burst
  task automatic run_cmd(input bit w, input logic [7:0] a, input int unsigned len,
                         input int unsigned max_stall, input int unsigned force_idx,
                         input int unsigned force_n, input int unsigned hold1, input bit abort);
    int unsigned stall, guard;
    logic [7:0]  b8;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = LEN_W'(len);
    tick(0, 8'h00);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_len = LEN_W'($urandom);
    if (len == 0) begin
      exp_done = 1'b1;
      tick(0, 8'h00);
      return;
    end
    exp_cmd_ready = 0; exp_busy = 1; exp_cen = 0; exp_addr = a; exp_alen = 0;
    repeat (T_ALE) tick(0, 8'h00);
    exp_alen = 1;
    repeat (T_AH) tick(0, 8'h00);
    for (int unsigned b = 0; b < len; b++) begin
      if (w) begin
        stall = (b == force_idx) ? force_n : $urandom_range(0, max_stall);
        wr_valid = 1'b0;
        repeat (stall) tick(0, 8'h00);
        b8 = (wq.size() > 0) ? wq.pop_front() : 8'($urandom);
        wr_valid = 1'b1; wr_data = b8;
        tick(0, 8'h00);
        wr_valid = 1'b0; wr_data = 8'($urandom);
        exp_wrn = 0; exp_oe = 1; exp_d_o = b8; exp_wr_ready = 1;
        for (int unsigned s = 0; s < T_STB; s++) begin
          if (abort && s == 1) begin mid_reset(); return; end
          tick(0, 8'h00);
        end
        exp_wrn = 1;
      end else begin
        guard = 0;
        while (exp_rd_valid && !rd_ready) begin
          tick(0, 8'h00);
          guard++;
          if (guard > 500) begin
            errors++;
            $display("FAIL rd_wait_bound @%0t: got stall>500 expected consumer progress", $time);
            break;
          end
        end
        tick(0, 8'h00);
        b8 = a + 8'(b) + rd_seed;
        exp_rdn = 0; usb_d_i = b8;
        for (int unsigned s = 0; s < T_STB; s++) begin
          if (s == T_STB - 1 && b == 0) rd_hold = hold1;
          tick(s == T_STB - 1, b8);
        end
        exp_rdn = 1; usb_d_i = ~b8;
      end
      repeat (T_REC) tick(0, 8'h00);
      exp_oe = 0;
      if (b == len - 1) begin
        exp_cen = 1; exp_done = 1; exp_busy = 0; exp_cmd_ready = 1;
      end
    end
    tick(0, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog @%0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_data = 0; wr_valid = 0; rd_ready = 0; usb_d_i = 0;
    set_reset_exp();
    rdy_mode = 1; rd_hold = 0; rd_seed = 0;
    clr_mon();
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_strobes", {28'd0, usb_alen, usb_cen, usb_rdn, usb_wrn}, 32'hF);
    tick(0, 8'h00);

    // 1: single write
    clr_mon(); wq.delete(); wq.push_back(8'h5C);
    run_cmd(1, 8'h2A, 1, 0, 99, 0, 0, 0);
    chk("t1_ale_low_cycles", mon_alen_low, 2);
    chk("t1_ale_pulses", mon_ale_pulses, 1);
    chk("t1_wrn_low_cycles", mon_wrn_low, 3);
    chk("t1_wr_byte", 32'(wr_seen[0]), 32'h5C);
    chk("t1_done_pulses", mon_done, 1);
    tick(0, 8'h00);

    // 2: read burst of 4 with an always-ready consumer
    clr_mon(); rd_seed = 0;
    run_cmd(0, 8'h10, 4, 0, 99, 0, 0, 0);
    chk("t2_rd_count", consumed.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_rd_byte", 32'(consumed[i]), 32'h10 + 32'(i));
    chk("t2_ale_pulses", mon_ale_pulses, 1);
    chk("t2_oe_cycles", mon_oe_cycles, 0);
    chk("t2_rdn_pulses", mon_rdn_pulses, 4);
    tick(0, 8'h00);

    // 3: write burst with a 5-cycle producer stall before byte 2
    clr_mon(); wq.delete(); wq.push_back(8'hA1); wq.push_back(8'hB2); wq.push_back(8'hC3);
    run_cmd(1, 8'h33, 3, 0, 1, 5, 0, 0);
    chk("t3_wrn_pulses", mon_wrn_pulses, 3);
    chk("t3_byte0", 32'(wr_seen[0]), 32'hA1);
    chk("t3_byte1", 32'(wr_seen[1]), 32'hB2);
    chk("t3_byte2", 32'(wr_seen[2]), 32'hC3);
    tick(0, 8'h00);

    // 4: read burst with consumer back-pressure after byte 1
    clr_mon();
    run_cmd(0, 8'h80, 2, 0, 99, 0, 10, 0);
    chk("t4_rdn_pulses", mon_rdn_pulses, 2);
    chk("t4_rd_count", consumed.size(), 2);
    chk("t4_byte0", 32'(consumed[0]), 32'h80);
    chk("t4_byte1", 32'(consumed[1]), 32'h81);
    tick(0, 8'h00);

    // 5: zero-length command
    clr_mon();
    run_cmd(1, 8'h55, 0, 0, 99, 0, 0, 0);
    chk("t5_done_pulses", mon_done, 1);
    chk("t5_strobe_cycles", mon_strobe_low, 0);
    chk("t5_cmd_ready_low", mon_cmd_ready_low, 0);
    tick(0, 8'h00);

    // 6: reset during a write strobe, then a normal write afterwards
    run_cmd(1, 8'h77, 2, 0, 99, 0, 0, 1);
    tick(0, 8'h00);
    chk("t6_idle_ready", 32'(cmd_ready), 32'd1);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    clr_mon(); wq.delete(); wq.push_back(8'h3E);
    run_cmd(1, 8'h42, 1, 0, 99, 0, 0, 0);
    chk("t6_recover_byte", 32'(wr_seen[0]), 32'h3E);

    // Randomized commands with random producer stalls and consumer readiness
    rdy_mode = 0;
    for (int n = 0; n < 40; n++) begin
      rd_seed = 8'($urandom);
      run_cmd(1'($urandom), 8'($urandom), $urandom_range(0, 6), 3, 99, 0, 0, 0);
      repeat ($urandom_range(0, 3)) tick(0, 8'h00);
    end
    tick(0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
